// File: rtl/m_pcpi_frontend_pkg.sv
// Shared types and constants for the PCPI M-extension frontend.
package m_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } m_op_e;

endpackage

// File: rtl/m_pcpi_frontend_if.sv
// Bus bundles: CPU-side PCPI port and the request/response port to the M unit.
interface pcpi_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    // CPU side
    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
    // Co-processor side
    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

interface m_if;
    logic        m_valid;
    logic [31:0] m_instruction;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_wr;
    logic [31:0] m_rd;
    logic        m_busy;
    logic        m_ready;

    // Frontend side
    modport master (
        output m_valid, m_instruction, m_rs1, m_rs2,
        input  m_wr, m_rd, m_busy, m_ready
    );
    // M unit side
    modport slave (
        input  m_valid, m_instruction, m_rs1, m_rs2,
        output m_wr, m_rd, m_busy, m_ready
    );
endinterface

// File: rtl/m_pcpi_frontend_decode.sv
// Combinational decode of RV32M instructions: flags MUL/DIV/REM and extracts funct3.
module m_insn_decode
    import m_pkg::*;
(
    input  logic [31:0] i_insn,
    output logic        o_is_m,
    output m_op_e       o_funct3
);
    // Register and rd fields are irrelevant to classification.
    logic w_unused_fields;

    assign o_is_m          = (i_insn[6:0] == OPCODE_OP) && (i_insn[31:25] == FUNCT7_MULDIV);
    assign o_funct3        = m_op_e'(i_insn[14:12]);
    assign w_unused_fields = ^{i_insn[24:15], i_insn[11:7]};

endmodule

// File: rtl/m_pcpi_frontend.sv
// PCPI frontend: accepts M instructions from the CPU, issues them to the M unit,
// returns the result, and handles abort, timeout and drain of abandoned requests.
module m_pcpi_frontend
    import m_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    pcpi_if.slave       pcpi,
    m_if.master         m,
    output logic        err_timeout,
    output logic [31:0] done_count
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        r_state;
    state_e        w_next;
    logic          r_rearm;
    logic [31:0]   r_req_insn;
    logic [31:0]   r_req_rs1;
    logic [31:0]   r_req_rs2;
    logic [31:0]   r_res_rd;
    logic          r_res_wr;
    logic [31:0]   r_done_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;

    logic          w_is_m;
    m_op_e         w_funct3;
    logic          w_unused_funct3;
    logic          w_accept;
    logic          w_active;
    logic          w_wait;
    logic          w_m_valid;
    logic          w_capture;
    logic          w_tmo_hit;

    m_insn_decode u_dec (
        .i_insn   (pcpi.pcpi_insn),
        .o_is_m   (w_is_m),
        .o_funct3 (w_funct3)
    );

    // The op selector is consumed by the M unit from m_instruction, not here.
    assign w_unused_funct3 = ^w_funct3;

    // resetn gates acceptance so pcpi_wait stays low while reset is held.
    assign w_accept = resetn && pcpi.pcpi_valid && w_is_m && r_rearm;
    assign w_active = (r_state == ISSUE) || (r_state == WAIT);

    // Next-state and per-state strobes; abort beats a coincident m_ready, which beats timeout.
    always_comb begin
        w_next    = r_state;
        w_wait    = 1'b0;
        w_m_valid = 1'b0;
        w_capture = 1'b0;
        w_tmo_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = ISSUE;
                    w_wait = 1'b1;
                end
            end
            ISSUE, WAIT: begin
                w_wait    = 1'b1;
                w_m_valid = (r_state == ISSUE);
                if (!pcpi.pcpi_valid) begin
                    w_next = m.m_ready ? IDLE : DRAIN;
                end else if (m.m_ready) begin
                    w_next    = RESP;
                    w_capture = 1'b1;
                end else if (r_tmo_cnt >= TMO_LAST) begin
                    w_next    = DRAIN;
                    w_tmo_hit = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP:    w_next = IDLE;
            DRAIN:   if (m.m_ready || !m.m_busy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Rearm: a lingering pcpi_valid after ready must not re-issue the same instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                   r_rearm <= 1'b1;
        else if (r_state == RESP)                      r_rearm <= 1'b0;
        else if (r_state == IDLE && !pcpi.pcpi_valid)  r_rearm <= 1'b1;
    end

    // Request registers latch on acceptance and hold through the operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req_insn <= '0;
            r_req_rs1  <= '0;
            r_req_rs2  <= '0;
        end else if (r_state == IDLE && w_accept) begin
            r_req_insn <= pcpi.pcpi_insn;
            r_req_rs1  <= pcpi.pcpi_rs1;
            r_req_rs2  <= pcpi.pcpi_rs2;
        end
    end

    // Result registers capture the M unit response on a non-aborted m_ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_res_rd <= '0;
            r_res_wr <= 1'b0;
        end else if (w_capture) begin
            r_res_rd <= m.m_rd;
            r_res_wr <= m.m_wr;
        end
    end

    // Completion counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)              r_done_cnt <= '0;
        else if (r_state == RESP) r_done_cnt <= r_done_cnt + 32'd1;
    end

    // Timeout counter: cleared on entry to ISSUE, counts ISSUE/WAIT cycles; reaches
    // TIMEOUT_CYCLES exactly when err_timeout pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          r_tmo_cnt <= '0;
        else if (r_state == IDLE && w_accept) r_tmo_cnt <= '0;
        else if (w_active)                    r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end

    // Timeout pulse lands in the first DRAIN cycle, where pcpi_wait is already low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_err <= 1'b0;
        else         r_err <= w_tmo_hit;
    end

    assign pcpi.pcpi_wait    = w_wait;
    assign pcpi.pcpi_ready   = (r_state == RESP);
    assign pcpi.pcpi_rd      = (r_state == RESP) ? r_res_rd : 32'd0;
    assign pcpi.pcpi_wr      = (r_state == RESP) && r_res_wr;
    assign m.m_valid         = w_m_valid;
    assign m.m_instruction   = (r_state != IDLE) ? r_req_insn : 32'd0;
    assign m.m_rs1           = (r_state != IDLE) ? r_req_rs1  : 32'd0;
    assign m.m_rs2           = (r_state != IDLE) ? r_req_rs2  : 32'd0;
    assign err_timeout       = r_err;
    assign done_count        = r_done_cnt;

endmodule

// File: tb/tb_m_pcpi_frontend.sv
// Directed bench for m_pcpi_frontend: handshake, lingering valid, non-M insn,
// abort/drain, abort with coincident ready, timeout, and async reset mid-operation.
module tb_m_pcpi_frontend;

    localparam logic [31:0] INSN_MUL  = 32'h02B50533;
    localparam logic [31:0] INSN_ADD  = 32'h00B50533;
    localparam logic [31:0] INSN_DIVU = 32'h02B55533;

    logic        clk = 1'b0;
    logic        resetn;
    logic        err_timeout;
    logic [31:0] done_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_mvalid = 0;

    pcpi_if u_pcpi ();
    m_if    u_m ();

    m_pcpi_frontend #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pcpi        (u_pcpi),
        .m           (u_m),
        .err_timeout (err_timeout),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (u_m.m_valid === 1'b1) n_mvalid++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic v, input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        u_pcpi.pcpi_valid = v;
        u_pcpi.pcpi_insn  = insn;
        u_pcpi.pcpi_rs1   = a;
        u_pcpi.pcpi_rs2   = b;
    endtask

    task automatic unit(input logic busy, input logic rdy, input logic [31:0] rd, input logic wr);
        u_m.m_busy  = busy;
        u_m.m_ready = rdy;
        u_m.m_rd    = rd;
        u_m.m_wr    = wr;
    endtask

    initial begin
        // Reset held with a valid M request present: everything must stay 0.
        resetn = 1'b0;
        cpu(1'b1, INSN_MUL, 32'd7, 32'd6);
        unit(1'b0, 1'b0, 32'd0, 1'b0);
        #3;
        chk("rst_wait",   u_pcpi.pcpi_wait,   0);
        chk("rst_ready",  u_pcpi.pcpi_ready,  0);
        chk("rst_rd",     u_pcpi.pcpi_rd,     0);
        chk("rst_wr",     u_pcpi.pcpi_wr,     0);
        chk("rst_mvalid", u_m.m_valid,        0);
        chk("rst_minsn",  u_m.m_instruction,  0);
        chk("rst_err",    err_timeout,        0);
        chk("rst_done",   done_count,         0);
        cpu(1'b0, 32'd0, 32'd0, 32'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // MUL 7*6: unit answers in the third cycle after issue.
        tick(); cpu(1'b1, INSN_MUL, 32'd7, 32'd6); settle();
        chk("a_accept_wait", u_pcpi.pcpi_wait, 1);
        chk("a_accept_mvalid", u_m.m_valid, 0);
        tick(); unit(1'b1, 1'b0, 32'd0, 1'b0); settle();
        chk("a_issue_mvalid", u_m.m_valid, 1);
        chk("a_issue_insn", u_m.m_instruction, INSN_MUL);
        chk("a_issue_rs1", u_m.m_rs1, 32'd7);
        chk("a_issue_rs2", u_m.m_rs2, 32'd6);
        chk("a_issue_wait", u_pcpi.pcpi_wait, 1);
        tick(); settle();
        chk("a_wait_mvalid", u_m.m_valid, 0);
        chk("a_wait_hold", u_m.m_instruction, INSN_MUL);
        chk("a_wait_wait", u_pcpi.pcpi_wait, 1);
        tick(); unit(1'b1, 1'b1, 32'd42, 1'b1); settle();
        chk("a_wait2_ready", u_pcpi.pcpi_ready, 0);
        tick(); unit(1'b0, 1'b0, 32'd0, 1'b0); settle();
        chk("a_resp_ready", u_pcpi.pcpi_ready, 1);
        chk("a_resp_rd", u_pcpi.pcpi_rd, 32'd42);
        chk("a_resp_wr", u_pcpi.pcpi_wr, 1);
        chk("a_resp_wait", u_pcpi.pcpi_wait, 0);
        chk("a_resp_done", done_count, 0);
        // pcpi_valid lingers two cycles after ready: no re-issue.
        tick(); settle();
        chk("a_post_ready", u_pcpi.pcpi_ready, 0);
        chk("a_post_rd", u_pcpi.pcpi_rd, 0);
        chk("a_post_wait", u_pcpi.pcpi_wait, 0);
        chk("a_post_done", done_count, 1);
        chk("a_post_minsn", u_m.m_instruction, 0);
        tick(); settle();
        chk("a_linger_wait", u_pcpi.pcpi_wait, 0);
        chk("a_linger_mvalid", u_m.m_valid, 0);
        tick(); cpu(1'b0, 32'd0, 32'd0, 32'd0); settle();
        chk("a_one_mvalid", n_mvalid, 1);

        // ADD held valid 10 cycles: frontend stays silent.
        tick(); cpu(1'b1, INSN_ADD, 32'd1, 32'd2);
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("b_add_quiet", {u_pcpi.pcpi_wait, u_m.m_valid, u_pcpi.pcpi_ready, u_pcpi.pcpi_wr}, 0);
            tick();
        end
        cpu(1'b0, 32'd0, 32'd0, 32'd0);
        tick();

        // Abort in WAIT cycle 2, unit answers 3 cycles later into DRAIN.
        tick(); cpu(1'b1, INSN_MUL, 32'd3, 32'd5); settle();
        chk("c_accept_wait", u_pcpi.pcpi_wait, 1);
        tick(); unit(1'b1, 1'b0, 32'd0, 1'b0);
        tick();
        tick(); cpu(1'b0, 32'd0, 32'd0, 32'd0); settle();
        chk("c_wait2_wait", u_pcpi.pcpi_wait, 1);
        tick(); settle();
        chk("c_drain_wait", u_pcpi.pcpi_wait, 0);
        chk("c_drain_ready1", u_pcpi.pcpi_ready, 0);
        tick(); settle();
        chk("c_drain_ready2", u_pcpi.pcpi_ready, 0);
        tick(); unit(1'b1, 1'b1, 32'd15, 1'b1); settle();
        chk("c_drain_ready3", u_pcpi.pcpi_ready, 0);
        chk("c_drain_rd", u_pcpi.pcpi_rd, 0);
        tick(); unit(1'b0, 1'b0, 32'd0, 1'b0); settle();
        chk("c_idle_ready", u_pcpi.pcpi_ready, 0);
        chk("c_done_same", done_count, 1);

        // Abort coinciding with m_ready: straight to IDLE, no ready.
        tick(); cpu(1'b1, INSN_MUL, 32'd2, 32'd2); settle();
        chk("e_accept_wait", u_pcpi.pcpi_wait, 1);
        tick(); unit(1'b1, 1'b0, 32'd0, 1'b0);
        tick(); cpu(1'b0, 32'd0, 32'd0, 32'd0); unit(1'b1, 1'b1, 32'd99, 1'b1);
        tick(); unit(1'b1, 1'b0, 32'd0, 1'b0); settle();
        chk("e_no_ready", u_pcpi.pcpi_ready, 0);
        chk("e_no_rd", u_pcpi.pcpi_rd, 0);
        // Busy is still high, so only IDLE (not DRAIN) can accept here.
        cpu(1'b1, INSN_DIVU, 32'd9, 32'd3); settle();
        chk("e_idle_accept", u_pcpi.pcpi_wait, 1);

        // Timeout with TIMEOUT_CYCLES=8: cycle 0 is ISSUE, err_timeout in cycle 8.
        tick(); settle();
        chk("d_issue_mvalid", u_m.m_valid, 1);
        for (int k = 1; k < 8; k++) begin
            tick(); settle();
            chk("d_waiting", {u_pcpi.pcpi_wait, err_timeout}, 32'h2);
        end
        tick(); settle();
        chk("d_err_pulse", err_timeout, 1);
        chk("d_wait_drop", u_pcpi.pcpi_wait, 0);
        cpu(1'b0, 32'd0, 32'd0, 32'd0);
        tick(); settle();
        chk("d_err_once", err_timeout, 0);
        chk("d_c9_wait", u_pcpi.pcpi_wait, 0);
        tick(); cpu(1'b1, INSN_DIVU, 32'd55, 32'd5); settle();
        chk("d_drain_no_accept", u_pcpi.pcpi_wait, 0);
        tick(); settle();
        chk("d_c11_wait", u_pcpi.pcpi_wait, 0);
        tick(); unit(1'b0, 1'b0, 32'd0, 1'b0); settle();
        chk("d_c12_wait", u_pcpi.pcpi_wait, 0);
        tick(); settle();
        chk("d_idle_accept", u_pcpi.pcpi_wait, 1);

        // Async reset while in WAIT, then a clean DIVU 100/7.
        tick(); unit(1'b1, 1'b0, 32'd0, 1'b0); settle();
        chk("f_issue_mvalid", u_m.m_valid, 1);
        tick(); settle();
        chk("f_wait_wait", u_pcpi.pcpi_wait, 1);
        resetn = 1'b0; settle();
        chk("f_rst_wait", u_pcpi.pcpi_wait, 0);
        chk("f_rst_ready", u_pcpi.pcpi_ready, 0);
        chk("f_rst_minsn", u_m.m_instruction, 0);
        chk("f_rst_mrs1", u_m.m_rs1, 0);
        chk("f_rst_done", done_count, 0);
        cpu(1'b0, 32'd0, 32'd0, 32'd0); unit(1'b0, 1'b0, 32'd0, 1'b0);
        tick(); tick();
        resetn = 1'b1;
        tick(); settle();
        chk("f_no_ready", u_pcpi.pcpi_ready, 0);
        tick(); cpu(1'b1, INSN_DIVU, 32'd100, 32'd7); settle();
        chk("f_accept_wait", u_pcpi.pcpi_wait, 1);
        // Unit answers in the issue cycle; 100/7 = 14.
        tick(); unit(1'b1, 1'b1, 32'd14, 1'b1); settle();
        chk("f_issue_minsn", u_m.m_instruction, INSN_DIVU);
        chk("f_issue_rs1", u_m.m_rs1, 32'd100);
        chk("f_issue_rs2", u_m.m_rs2, 32'd7);
        tick(); unit(1'b0, 1'b0, 32'd0, 1'b0); settle();
        chk("f_resp_ready", u_pcpi.pcpi_ready, 1);
        chk("f_resp_rd", u_pcpi.pcpi_rd, 32'd14);
        chk("f_resp_wr", u_pcpi.pcpi_wr, 1);
        tick(); cpu(1'b0, 32'd0, 32'd0, 32'd0); settle();
        chk("f_done", done_count, 1);
        chk("f_idle_ready", u_pcpi.pcpi_ready, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_pcpi_frontend.md
M_PCPI_FRONTEND -- requirements
Module: m_pcpi_frontend

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max cycles in ISSUE+WAIT before abandoning a request.
REQ-002 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have pcpi_valid, input, 1: CPU co-processor request valid.
REQ-005 SHALL have pcpi_insn, input, 32: CPU instruction word.
REQ-006 SHALL have pcpi_rs1 and pcpi_rs2, input, 32 each: CPU operands.
REQ-007 SHALL have pcpi_wr, output, 1: write rd to register file.
REQ-008 SHALL have pcpi_rd, output, 32: result to CPU.
REQ-009 SHALL have pcpi_wait, output, 1: tells CPU an M instruction is in progress.
REQ-010 SHALL have pcpi_ready, output, 1: one-cycle result strobe to CPU.
REQ-011 SHALL have m_valid, output, 1; m_instruction, output, 32; m_rs1 and m_rs2, output, 32 each: request to the M unit.
REQ-012 SHALL have m_wr, input, 1; m_rd, input, 32; m_busy, input, 1; m_ready, input, 1: M unit response.
REQ-013 SHALL have err_timeout, output, 1: one-cycle pulse on abandoned request.
REQ-014 SHALL have done_count, output, 32: completed-instruction counter.

Function
REQ-015 SHALL decode is_m = (insn[6:0]==7'b0110011) && (insn[31:25]==7'b0000001); non-M instructions produce no wait, ready or wr.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-017 IDLE: on pcpi_valid && is_m && rearm, SHALL latch insn/rs1/rs2 into request registers and go ISSUE; pcpi_wait SHALL assert combinationally in that same cycle.
REQ-018 ISSUE: SHALL drive m_valid=1 for exactly one cycle with latched values; next state WAIT unless m_ready (then RESP).
REQ-019 m_instruction/m_rs1/m_rs2 SHALL hold latched values from ISSUE until return to IDLE.
REQ-020 WAIT: on m_ready SHALL capture m_rd and m_wr into result registers and go RESP.
REQ-021 pcpi_wait SHALL be 1 in ISSUE and WAIT, 0 in RESP, DRAIN, and IDLE except per REQ-017.
REQ-022 RESP: SHALL assert pcpi_ready=1 for one cycle with captured pcpi_rd/pcpi_wr, increment done_count (wraps at 2^32), clear rearm, go IDLE.
REQ-023 pcpi_rd SHALL be 0 and pcpi_wr 0 outside RESP.
REQ-024 rearm SHALL set when pcpi_valid is sampled low in IDLE; prevents re-issuing the same instruction if valid lingers after ready.
REQ-025 Abort: pcpi_valid low in ISSUE or WAIT SHALL go DRAIN (discard result); if m_ready coincides, abort wins, go IDLE directly, no ready.
REQ-026 DRAIN: SHALL wait for m_ready or !m_busy, then IDLE; no new request accepted in DRAIN.
REQ-027 Timeout counter SHALL clear on entering ISSUE, increment each ISSUE/WAIT cycle; at TIMEOUT_CYCLES without m_ready SHALL pulse err_timeout, deassert pcpi_wait, go DRAIN.
REQ-028 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Reset
REQ-029 resetn low SHALL immediately force state IDLE, rearm=1, all outputs 0, request/result registers 0, done_count 0, timeout counter 0.
REQ-030 Reset mid-operation SHALL discard the request with no ready pulse; first request after release SHALL be accepted normally.

Structure
REQ-031 Shared package m_pkg SHALL hold the state enum, OPCODE_OP (7'b0110011), FUNCT7_MULDIV (7'b0000001), and the funct3 op enum (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-032 Decode SHALL be one combinational sub-module m_insn_decode (insn in, is_m and funct3 out); everything else in m_pcpi_frontend.

Verification
REQ-033 MUL insn 0x02B50533, rs1=7, rs2=6, unit ready after 3 cycles with m_rd=42 -> one pcpi_ready, pcpi_rd=42, pcpi_wr=1, done_count=1.
REQ-034 ADD insn 0x00B50533 with pcpi_valid high 10 cycles -> m_valid, pcpi_wait, pcpi_ready all 0 throughout.
REQ-035 pcpi_valid held high 2 cycles after ready -> exactly one m_valid pulse, done_count=1.
REQ-036 pcpi_valid dropped in WAIT cycle 2, m_ready 3 cycles later -> no pcpi_ready, DRAIN then IDLE, done_count unchanged.
REQ-037 TIMEOUT_CYCLES=8, m_ready never asserted, m_busy falls at cycle 12 -> err_timeout pulse at cycle 8, pcpi_wait low from then, IDLE after m_busy low.
REQ-038 resetn pulsed low in WAIT -> all outputs 0 asynchronously; next DIVU 100/7 returns pcpi_rd=14.
